// File: rtl/pd_pkg.sv
// pd_pkg: shared widths, ALU opcodes, operand-select encodings and the bubble control bundle
package pd_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // Second ALU operand source; both 10 and 11 select the immediate
    localparam logic [1:0] SEL_RS2   = 2'b00;
    localparam logic [1:0] SEL_SHAMT = 2'b01;
    localparam logic [1:0] SEL_IMM   = 2'b10;

    typedef struct packed {
        logic       pc_reg1_sel;
        logic [1:0] imm_rs2_shamt_sel;
        alu_op_t    alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        pc_reg1_sel:       1'b0,
        imm_rs2_shamt_sel: SEL_RS2,
        alu_op:            ALU_ADD,
        mem_read:          1'b0,
        mem_write:         1'b0,
        reg_write:         1'b0,
        branch:            1'b0,
        jump:              1'b0
    };

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// load_use_detect: flags a decode instruction that reads the register a load in execute is writing
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             valid_x,
    input  logic             mem_read_x,
    input  logic [REG_W-1:0] rd_x,
    input  logic             valid_d,
    input  logic             rs1_used_d,
    input  logic [REG_W-1:0] rs1_d,
    input  logic             rs2_used_d,
    input  logic [REG_W-1:0] rs2_d,
    output logic             hazard
);

    assign hazard = valid_x & mem_read_x & (rd_x != '0) & valid_d &
                    ((rs1_used_d & (rs1_d == rd_x)) | (rs2_used_d & (rs2_d == rd_x)));

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: decode-to-execute register with load-use interlock, flush, write-through and bubble counter
module id_ex_pipe
    import pd_pkg::*;
#(
    parameter int XLEN  = pd_pkg::XLEN,
    parameter int REG_W = pd_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic [XLEN-1:0]  shamt_d,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic [XLEN-1:0]  rs1_data_d,
    input  logic [XLEN-1:0]  rs2_data_d,
    input  logic             pc_reg1_sel_d,
    input  logic [1:0]       imm_rs2_shamt_sel_d,
    input  logic [3:0]       alu_op_d,
    input  logic             mem_read_d,
    input  logic             mem_write_d,
    input  logic             reg_write_d,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic [REG_W-1:0] rd_wb,
    input  logic [XLEN-1:0]  rd_data_wb,
    input  logic             reg_write_wb,
    input  logic             flush_x,
    input  logic             hold,
    output logic             valid_x,
    output logic [XLEN-1:0]  pc_x,
    output logic [XLEN-1:0]  imm_x,
    output logic [XLEN-1:0]  shamt_x,
    output logic [REG_W-1:0] rs1_x,
    output logic [REG_W-1:0] rs2_x,
    output logic [REG_W-1:0] rd_x,
    output logic             rs1_used_x,
    output logic             rs2_used_x,
    output logic [XLEN-1:0]  rs1_data_x,
    output logic [XLEN-1:0]  rs2_data_x,
    output logic             pc_reg1_sel_x,
    output logic [1:0]       imm_rs2_shamt_sel_x,
    output logic [3:0]       alu_op_x,
    output logic             mem_read_x,
    output logic             mem_write_x,
    output logic             reg_write_x,
    output logic             branch_x,
    output logic             jump_x,
    output logic             stall_d,
    output logic [CNT_W-1:0] bubble_count
);

    logic  hazard, bubble, fwd1, fwd2;
    ctrl_t ctrl_d, ctrl_x;

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .valid_x    (valid_x),
        .mem_read_x (mem_read_x),
        .rd_x       (rd_x),
        .valid_d    (valid_d),
        .rs1_used_d (rs1_used_d),
        .rs1_d      (rs1_d),
        .rs2_used_d (rs2_used_d),
        .rs2_d      (rs2_d),
        .hazard     (hazard)
    );

    // An empty decode slot is captured exactly like an inserted bubble
    assign bubble  = flush_x | hazard | ~valid_d;
    assign stall_d = hold | (hazard & ~flush_x);
    assign fwd1    = reg_write_wb & (rd_wb != '0) & (rd_wb == rs1_d);
    assign fwd2    = reg_write_wb & (rd_wb != '0) & (rd_wb == rs2_d);

    assign ctrl_d = '{
        pc_reg1_sel:       pc_reg1_sel_d,
        imm_rs2_shamt_sel: imm_rs2_shamt_sel_d,
        alu_op:            alu_op_t'(alu_op_d),
        mem_read:          mem_read_d,
        mem_write:         mem_write_d,
        reg_write:         reg_write_d,
        branch:            branch_d,
        jump:              jump_d
    };

    assign pc_reg1_sel_x       = ctrl_x.pc_reg1_sel;
    assign imm_rs2_shamt_sel_x = ctrl_x.imm_rs2_shamt_sel;
    assign alu_op_x            = ctrl_x.alu_op;
    assign mem_read_x          = ctrl_x.mem_read;
    assign mem_write_x         = ctrl_x.mem_write;
    assign reg_write_x         = ctrl_x.reg_write;
    assign branch_x            = ctrl_x.branch;
    assign jump_x              = ctrl_x.jump;

    // Stage register: freeze on hold, otherwise load the decode fields or a bubble
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_x    <= 1'b0;
            pc_x       <= '0;
            imm_x      <= '0;
            shamt_x    <= '0;
            rs1_x      <= '0;
            rs2_x      <= '0;
            rd_x       <= '0;
            rs1_used_x <= 1'b0;
            rs2_used_x <= 1'b0;
            rs1_data_x <= '0;
            rs2_data_x <= '0;
            ctrl_x     <= CTRL_BUBBLE;
        end else if (!hold) begin
            valid_x    <= ~bubble;
            pc_x       <= bubble ? '0 : pc_d;
            imm_x      <= bubble ? '0 : imm_d;
            shamt_x    <= bubble ? '0 : shamt_d;
            rs1_x      <= bubble ? '0 : rs1_d;
            rs2_x      <= bubble ? '0 : rs2_d;
            rd_x       <= bubble ? '0 : rd_d;
            rs1_used_x <= ~bubble & rs1_used_d;
            rs2_used_x <= ~bubble & rs2_used_d;
            rs1_data_x <= bubble ? '0 : (fwd1 ? rd_data_wb : rs1_data_d);
            rs2_data_x <= bubble ? '0 : (fwd2 ? rd_data_wb : rs2_data_d);
            ctrl_x     <= bubble ? CTRL_BUBBLE : ctrl_d;
        end
    end

    // Saturating count of bubbles caused by load-use stalls only, not flushes
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            bubble_count <= '0;
        else if (!hold && hazard && !flush_x && !(&bubble_count))
            bubble_count <= bubble_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed plus randomized checks of id_ex_pipe against a behavioural model
module tb_id_ex_pipe;

    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, imm, shamt;
        logic [4:0]  rs1, rs2, rd;
        logic        rs1_used, rs2_used;
        logic [31:0] rs1_data, rs2_data;
        logic        pc_reg1_sel;
        logic [1:0]  sel;
        logic [3:0]  alu_op;
        logic        mem_read, mem_write, reg_write, branch, jump;
    } st_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    st_t  d = '0;
    st_t  act;
    st_t  mx = '0;
    logic [4:0]  rd_wb = '0;
    logic [31:0] rd_data_wb = '0;
    logic reg_write_wb = 1'b0, flush_x = 1'b0, hold = 1'b0;
    logic stall_d;
    logic [CNT_W-1:0] bubble_count;
    int   mcnt = 0;
    bit   stalled_at_edge = 0;
    int   n_tests = 0, n_fail = 0;

    always #5 clock = ~clock;

    id_ex_pipe #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .valid_d(d.valid), .pc_d(d.pc), .imm_d(d.imm), .shamt_d(d.shamt),
        .rs1_d(d.rs1), .rs2_d(d.rs2), .rd_d(d.rd),
        .rs1_used_d(d.rs1_used), .rs2_used_d(d.rs2_used),
        .rs1_data_d(d.rs1_data), .rs2_data_d(d.rs2_data),
        .pc_reg1_sel_d(d.pc_reg1_sel), .imm_rs2_shamt_sel_d(d.sel), .alu_op_d(d.alu_op),
        .mem_read_d(d.mem_read), .mem_write_d(d.mem_write), .reg_write_d(d.reg_write),
        .branch_d(d.branch), .jump_d(d.jump),
        .rd_wb(rd_wb), .rd_data_wb(rd_data_wb), .reg_write_wb(reg_write_wb),
        .flush_x(flush_x), .hold(hold),
        .valid_x(act.valid), .pc_x(act.pc), .imm_x(act.imm), .shamt_x(act.shamt),
        .rs1_x(act.rs1), .rs2_x(act.rs2), .rd_x(act.rd),
        .rs1_used_x(act.rs1_used), .rs2_used_x(act.rs2_used),
        .rs1_data_x(act.rs1_data), .rs2_data_x(act.rs2_data),
        .pc_reg1_sel_x(act.pc_reg1_sel), .imm_rs2_shamt_sel_x(act.sel), .alu_op_x(act.alu_op),
        .mem_read_x(act.mem_read), .mem_write_x(act.mem_write), .reg_write_x(act.reg_write),
        .branch_x(act.branch), .jump_x(act.jump),
        .stall_d(stall_d), .bubble_count(bubble_count)
    );

    // Does the instruction in decode read the register a load in execute will produce?
    function automatic bit model_hazard(st_t x, st_t dd);
        return x.valid && x.mem_read && x.rd != 0 && dd.valid &&
               ((dd.rs1_used && dd.rs1 == x.rd) || (dd.rs2_used && dd.rs2 == x.rd));
    endfunction

    function automatic bit model_stall(st_t x, st_t dd, bit h, bit f);
        return h || (model_hazard(x, dd) && !f);
    endfunction

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    // Reference model: what execute must hold after each edge
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mx = '0;
            mcnt = 0;
            stalled_at_edge = 0;
        end else begin
            stalled_at_edge = model_stall(mx, d, hold, flush_x);
            if (!hold) begin
                if (model_hazard(mx, d) && !flush_x && mcnt < CMAX) mcnt = mcnt + 1;
                if (flush_x || model_hazard(mx, d) || !d.valid) begin
                    mx = '0;
                end else begin
                    mx = d;
                    if (reg_write_wb && rd_wb != 0 && rd_wb == d.rs1) mx.rs1_data = rd_data_wb;
                    if (reg_write_wb && rd_wb != 0 && rd_wb == d.rs2) mx.rs2_data = rd_data_wb;
                end
            end
        end
    end

    // Every cycle, away from the edge, the DUT must agree with the model
    always @(negedge clock) begin
        n_tests++;
        if (act !== mx) begin
            n_fail++;
            $display("FAIL xstage: got %h expected %h at %0t", act, mx, $time);
        end
        check("stall_d", 64'(stall_d), 64'(model_stall(mx, d, hold, flush_x)));
        check("bubble_count", 64'(bubble_count), 64'(mcnt));
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic st_t instr(logic [31:0] pc, logic [4:0] rd, logic mem_read,
                                  logic [4:0] rs1, logic rs1_used, logic [4:0] rs2, logic rs2_used);
        st_t s = '0;
        s.valid = 1'b1;
        s.pc = pc;
        s.imm = pc + 32'h1000;
        s.rd = rd;
        s.mem_read = mem_read;
        s.reg_write = 1'b1;
        s.rs1 = rs1;
        s.rs1_used = rs1_used;
        s.rs2 = rs2;
        s.rs2_used = rs2_used;
        s.rs1_data = 32'h11110000 | pc;
        s.rs2_data = 32'h22220000 | pc;
        s.alu_op = 4'd3;
        return s;
    endfunction

    function automatic st_t rand_instr();
        st_t s;
        s.valid       = ($urandom_range(0, 9) != 0);
        s.pc          = $urandom;
        s.imm         = $urandom;
        s.shamt       = $urandom;
        s.rs1         = 5'($urandom_range(0, 7));
        s.rs2         = 5'($urandom_range(0, 7));
        s.rd          = 5'($urandom_range(0, 7));
        s.rs1_used    = 1'($urandom);
        s.rs2_used    = 1'($urandom);
        s.rs1_data    = $urandom;
        s.rs2_data    = $urandom;
        s.pc_reg1_sel = 1'($urandom);
        s.sel         = 2'($urandom);
        s.alu_op      = 4'($urandom);
        s.mem_read    = 1'($urandom);
        s.mem_write   = 1'($urandom);
        s.reg_write   = 1'($urandom);
        s.branch      = 1'($urandom);
        s.jump        = 1'($urandom);
        return s;
    endfunction

    initial begin
        int saved;
        #1 reset = 1'b1;
        #2 check("reset valid_x", 64'(act.valid), 64'd0);
        check("reset alu_op_x", 64'(act.alu_op), 64'd0);
        check("reset count", 64'(bubble_count), 64'd0);
        tick;
        reset = 1'b0;

        // Independent stream: each PC appears one cycle later, never a stall
        for (int i = 0; i < 3; i++) begin
            d = instr(32'(4 * i), 5'd10 + 5'(i), 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
            #1 check("stream stall", 64'(stall_d), 64'd0);
            tick;
            check("stream pc_x", 64'(act.pc), 64'(4 * i));
            check("stream valid_x", 64'(act.valid), 64'd1);
        end
        check("stream count", 64'(bubble_count), 64'd0);

        // Load x5 then a reader of x5: one stall, one bubble, then the reader
        d = instr(32'h40, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick;
        d = instr(32'h100, 5'd6, 1'b0, 5'd5, 1'b1, 5'd9, 1'b0);
        #1 check("load-use stall", 64'(stall_d), 64'd1);
        tick;
        check("bubble valid_x", 64'(act.valid), 64'd0);
        check("bubble cleared stall", 64'(stall_d), 64'd0);
        check("bubble count", 64'(bubble_count), 64'd1);
        tick;
        check("dependent pc_x", 64'(act.pc), 64'h100);
        check("dependent valid_x", 64'(act.valid), 64'd1);

        // Load into x0 never interlocks
        d = instr(32'h200, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick;
        d = instr(32'h204, 5'd8, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 check("x0 no stall", 64'(stall_d), 64'd0);
        tick;
        check("x0 no bubble", 64'(act.valid), 64'd1);

        // Flush with a hazard, first frozen by hold, then applied
        d = instr(32'h300, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick;
        saved = int'(bubble_count);
        d = instr(32'h304, 5'd7, 1'b0, 5'd1, 1'b0, 5'd6, 1'b1);
        flush_x = 1'b1;
        hold = 1'b1;
        #1 check("hold stall", 64'(stall_d), 64'd1);
        tick;
        check("hold keeps pc_x", 64'(act.pc), 64'h300);
        check("hold keeps valid_x", 64'(act.valid), 64'd1);
        hold = 1'b0;
        #1 check("flush+hazard stall", 64'(stall_d), 64'd0);
        tick;
        flush_x = 1'b0;
        check("flush bubble", 64'(act.valid), 64'd0);
        check("flush count", 64'(bubble_count), 64'(saved));

        // Write-through from write-back into rs2
        d = instr(32'h400, 5'd9, 1'b0, 5'd1, 1'b1, 5'd7, 1'b1);
        d.rs2_data = 32'h0;
        rd_wb = 5'd7;
        rd_data_wb = 32'hDEADBEEF;
        reg_write_wb = 1'b1;
        tick;
        check("wb rs2_data_x", 64'(act.rs2_data), 64'hDEADBEEF);
        check("wb rs1 untouched", 64'(act.rs1_data), 64'h11110400);
        reg_write_wb = 1'b0;

        // Reset between edges while a stall is pending
        d = instr(32'h500, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick;
        d = instr(32'h504, 5'd2, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
        #1 check("pre-reset stall", 64'(stall_d), 64'd1);
        #1 reset = 1'b1;
        #1 check("async reset valid_x", 64'(act.valid), 64'd0);
        check("async reset pc_x", 64'(act.pc), 64'd0);
        check("async reset mem_read_x", 64'(act.mem_read), 64'd0);
        check("async reset stall", 64'(stall_d), 64'd0);
        tick;
        reset = 1'b0;

        // Drive the counter into saturation
        for (int i = 0; i < CMAX + 5; i++) begin
            d = instr(32'h600, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            tick;
            d = instr(32'h604, 5'd1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
            tick;
            tick;
        end
        check("saturated count", 64'(bubble_count), 64'(CMAX));

        // Random traffic; decode repeats its instruction whenever it was stalled
        for (int i = 0; i < 4000; i++) begin
            if (!stalled_at_edge) d = rand_instr();
            if (!(flush_x && hold)) flush_x = ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 9) == 0);
            reg_write_wb = 1'($urandom);
            rd_wb = 5'($urandom_range(0, 7));
            rd_data_wb = $urandom;
            if (i == 2000) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
